// File: rtl/soc_system_led_pkg.sv
// rtl/soc_system_led_pkg.sv - register map, widths and reset defaults for the LED driver
// Ports: none (package).
package soc_system_led_pkg;

   typedef enum logic [1:0] {
      REG_DUTY      = 2'd0,
      REG_BLINK_EN  = 2'd1,
      REG_PRESCALE  = 2'd2,
      REG_STATUS    = 2'd3
   } reg_addr_e;

   localparam int PRESCALE_W       = 16;
   localparam int BLINK_CNT_W      = 8;
   localparam int STATUS_PHASE_BIT = 8;

   localparam logic [7:0]            DUTY_RST     = 8'hFF;
   localparam logic [PRESCALE_W-1:0] PRESCALE_RST = '0;

endpackage

// File: rtl/soc_system_led_tick_gen.sv
// rtl/soc_system_led_tick_gen.sv - programmable prescaler producing a one-cycle tick
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset
//   prescale - tick period minus one (0 = tick every cycle)
//   clear    - restart the count at zero; suppresses the tick this cycle
//   tick     - one-cycle pulse when the count reaches prescale
module soc_system_led_tick_gen
   import soc_system_led_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  clear,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt_q;
   logic [PRESCALE_W-1:0] cnt_d;

   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q + PRESCALE_W'(1);
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == prescale) begin
         tick  = 1'b1;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/soc_system_led_driver.sv
// rtl/soc_system_led_driver.sv - PWM dimming and blink gating of PIO LED requests
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset
//   led_req            - per-LED on/off request from the PIO
//   address, chipselect, write_n, writedata, readdata - Avalon-MM register slave
//   led_out            - registered active-high LED pin drive
module soc_system_led_driver
   import soc_system_led_pkg::*;
#(
   parameter int NUM_LEDS = 5,
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [NUM_LEDS-1:0] led_req,
   input  logic [1:0]          address,
   input  logic                chipselect,
   input  logic                write_n,
   input  logic [31:0]         writedata,
   output logic [31:0]         readdata,
   output logic [NUM_LEDS-1:0] led_out
);

   logic [PWM_BITS-1:0]    duty_q, duty_d;
   logic [NUM_LEDS-1:0]    blink_en_q, blink_en_d;
   logic [PRESCALE_W-1:0]  prescale_q, prescale_d;
   logic                   prescale_clr_q, prescale_clr_d;
   logic [NUM_LEDS-1:0]    led_req_q, led_req_d;
   logic [PWM_BITS-1:0]    pwm_cnt_q, pwm_cnt_d;
   logic [BLINK_CNT_W-1:0] blink_cnt_q, blink_cnt_d;
   logic [NUM_LEDS-1:0]    led_out_q, led_out_d;

   logic wr_en;
   logic tick;
   logic pwm_on;
   logic blink_phase;
   logic unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign blink_phase  = blink_cnt_q[BLINK_CNT_W-1];
   assign unused_wdata = ^writedata[31:PRESCALE_W];

   // All-ones duty is forced fully on; otherwise it would drop one count per period.
   assign pwm_on = (duty_q == {PWM_BITS{1'b1}}) | (pwm_cnt_q < duty_q);

   // The counter clear lands the cycle after the PRESCALE write so a tick
   // coinciding with the write still counts.
   soc_system_led_tick_gen u_tick_gen (
      .clk      (clk),
      .reset_n  (reset_n),
      .prescale (prescale_q),
      .clear    (prescale_clr_q),
      .tick     (tick)
   );

   always_comb begin
      duty_d         = duty_q;
      blink_en_d     = blink_en_q;
      prescale_d     = prescale_q;
      prescale_clr_d = 1'b0;
      led_req_d      = led_req;
      pwm_cnt_d      = pwm_cnt_q;
      blink_cnt_d    = blink_cnt_q;

      if (wr_en) begin
         case (reg_addr_e'(address))
            REG_DUTY:     duty_d     = writedata[PWM_BITS-1:0];
            REG_BLINK_EN: blink_en_d = writedata[NUM_LEDS-1:0];
            REG_PRESCALE: begin
               prescale_d     = writedata[PRESCALE_W-1:0];
               prescale_clr_d = 1'b1;
            end
            default: ;
         endcase
      end

      if (tick) begin
         pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
         if (pwm_cnt_q == {PWM_BITS{1'b1}}) begin
            blink_cnt_d = blink_cnt_q + BLINK_CNT_W'(1);
         end
      end

      led_out_d = led_req_q & {NUM_LEDS{pwm_on}} & (~blink_en_q | {NUM_LEDS{blink_phase}});
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         duty_q         <= PWM_BITS'(DUTY_RST);
         blink_en_q     <= '0;
         prescale_q     <= PRESCALE_RST;
         prescale_clr_q <= 1'b0;
         led_req_q      <= '0;
         pwm_cnt_q      <= '0;
         blink_cnt_q    <= '0;
         led_out_q      <= '0;
      end else begin
         duty_q         <= duty_d;
         blink_en_q     <= blink_en_d;
         prescale_q     <= prescale_d;
         prescale_clr_q <= prescale_clr_d;
         led_req_q      <= led_req_d;
         pwm_cnt_q      <= pwm_cnt_d;
         blink_cnt_q    <= blink_cnt_d;
         led_out_q      <= led_out_d;
      end
   end

   always_comb begin
      readdata = '0;
      case (reg_addr_e'(address))
         REG_DUTY:     readdata[PWM_BITS-1:0]   = duty_q;
         REG_BLINK_EN: readdata[NUM_LEDS-1:0]   = blink_en_q;
         REG_PRESCALE: readdata[PRESCALE_W-1:0] = prescale_q;
         REG_STATUS: begin
            readdata[NUM_LEDS-1:0]     = led_out_q;
            readdata[STATUS_PHASE_BIT] = blink_phase;
         end
         default: ;
      endcase
   end

   assign led_out = led_out_q;

endmodule

// File: tb/tb_soc_system_led_driver.sv
// tb/tb_soc_system_led_driver.sv - randomized and directed checks of the LED driver against a tick-count model
module tb_soc_system_led_driver;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [4:0]  led_req = '0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [4:0]  led_out;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;
   int cyc = 0;

   // Model: the pwm count and blink phase are derived from the total number
   // of prescaler ticks since reset rather than from separate counters.
   logic [7:0]  m_duty;
   logic [4:0]  m_blink;
   logic [15:0] m_p;
   logic [4:0]  m_reqq;
   logic [4:0]  m_led;
   int          m_start;
   int          m_ticks;

   soc_system_led_driver #(.NUM_LEDS(5), .PWM_BITS(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .led_req    (led_req),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .led_out    (led_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic m_phase();
      return ((m_ticks / 32768) % 2) != 0;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [1:0] a);
      case (a)
         2'd0:    return {24'b0, m_duty};
         2'd1:    return {27'b0, m_blink};
         2'd2:    return {16'b0, m_p};
         default: return {23'b0, m_phase(), 3'b0, m_led};
      endcase
   endfunction

   task automatic model_reset();
      m_duty  = 8'hFF;
      m_blink = '0;
      m_p     = '0;
      m_reqq  = '0;
      m_led   = '0;
      m_start = 0;
      m_ticks = 0;
   endtask

   // Applies the inputs of cycle cyc to the model at its closing clock edge.
   task automatic model_edge();
      int  pos;
      bit  tk;
      int  pwm;
      bit  on;
      pos = cyc - m_start;
      tk  = (pos >= 0) && ((pos % (int'(m_p) + 1)) == int'(m_p));
      pwm = m_ticks % 256;
      on  = (m_duty == 8'hFF) || (pwm < int'(m_duty));
      m_led = m_reqq & (on ? 5'h1F : 5'h00) & (~m_blink | (m_phase() ? 5'h1F : 5'h00));
      if (tk) m_ticks++;
      m_reqq = led_req;
      if (chipselect && !write_n) begin
         case (address)
            2'd0: m_duty  = writedata[7:0];
            2'd1: m_blink = writedata[4:0];
            2'd2: begin
               m_p     = writedata[15:0];
               m_start = cyc + 2;
            end
            default: ;
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      cyc++;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      step();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   // Asserts reset mid-cycle, checks immediate effects, then releases.
   task automatic do_reset();
      logic [31:0] rst_vals [4];
      rst_vals[0] = 32'h0000_00FF;
      rst_vals[1] = 32'h0;
      rst_vals[2] = 32'h0;
      rst_vals[3] = 32'h0;
      #2;
      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      #1;
      check("reset_led_out", 32'(led_out), 32'h0);
      model_reset();
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         #1;
         check("reset_readback", readdata, rst_vals[a]);
      end
      address = '0;
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
      cyc     = 0;
      run     = 1'b1;
   endtask

   always @(negedge clk) begin
      if (run && reset_n) begin
         check("led_out", 32'(led_out), 32'(m_led));
         check("readdata", readdata, exp_rd(address));
      end
   end

   initial begin
      int hi0;
      int hi1;
      int other;
      int r;
      logic [31:0] d;
      logic [1:0]  a;

      // Defaults: all LEDs follow led_req after two cycles.
      do_reset();
      led_req = 5'h1F;
      step();
      check("dflt_cyc1", 32'(led_out), 32'h0);
      step();
      check("dflt_cyc2", 32'(led_out), 32'h1F);
      address = 2'd3;
      while (cyc < 20) step();
      check("dflt_cyc20", 32'(led_out), 32'h1F);
      check("dflt_status", readdata, 32'h1F);

      // Blink on bit1 only, full duty, tick every cycle.
      do_reset();
      led_req = 5'h03;
      wr(2'd1, 32'h02);
      address = 2'd3;
      while (cyc < 100) step();
      hi0 = 0;
      hi1 = 0;
      for (int i = 0; i < 65536; i++) begin
         hi0 += int'(led_out[0]);
         hi1 += int'(led_out[1]);
         if (cyc == 16000) begin
            check("blink_phase_lo", 32'(readdata[8]), 32'h0);
            check("blink_bit1_lo", 32'(led_out[1]), 32'h0);
         end
         if (cyc == 49000) begin
            check("blink_phase_hi", 32'(readdata[8]), 32'h1);
            check("blink_bit1_hi", 32'(led_out[1]), 32'h1);
         end
         step();
      end
      check("blink_bit0_count", 32'(hi0), 32'd65536);
      check("blink_bit1_count", 32'(hi1), 32'd32768);

      // Randomized traffic against the model, then reset mid-run.
      for (int i = 0; i < 4000; i++) begin
         led_req = 5'($urandom);
         r = $urandom_range(0, 7);
         if (r == 0) begin
            a = 2'($urandom);
            d = $urandom;
            if (a == 2'd2) d[15:0] = 16'($urandom_range(0, 5));
            if (a == 2'd0 && $urandom_range(0, 2) == 0) d[7:0] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            wr(a, d);
         end else begin
            chipselect = (r == 1);
            write_n    = (r != 2);
            address    = 2'($urandom);
            step();
            chipselect = 1'b0;
            write_n    = 1'b1;
         end
      end
      do_reset();

      // DUTY=64 at full tick rate: 64 of every 256 cycles on.
      led_req = 5'h01;
      wr(2'd0, 32'd64);
      while (cyc < 300) step();
      hi0   = 0;
      other = 0;
      for (int i = 0; i < 256; i++) begin
         hi0   += int'(led_out[0]);
         other += int'(led_out[4:1] != 4'h0);
         step();
      end
      check("duty64_on_count", 32'(hi0), 32'd64);
      check("duty64_others", 32'(other), 32'd0);

      // DUTY=0 blanks everything; DUTY=255 restores two cycles after the write.
      do_reset();
      led_req = 5'h15;
      wr(2'd0, 32'd0);
      while (cyc < 10) step();
      other = 0;
      for (int i = 0; i < 300; i++) begin
         other += int'(led_out != 5'h0);
         step();
      end
      check("duty0_on_count", 32'(other), 32'd0);
      wr(2'd0, 32'hFF);
      check("duty255_w1", 32'(led_out), 32'h0);
      step();
      check("duty255_w2", 32'(led_out), 32'h15);

      // PRESCALE=3 with DUTY=1: pwm_cnt==0 lasts 4 cycles per 1024.
      do_reset();
      led_req = 5'h01;
      wr(2'd2, 32'd3);
      wr(2'd0, 32'd1);
      while (cyc < 2000) step();
      hi0 = 0;
      for (int i = 0; i < 1024; i++) begin
         hi0 += int'(led_out[0]);
         step();
      end
      check("presc3_on_count", 32'(hi0), 32'd4);
      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(0, 5)) step();
         wr(2'd2, 32'd3);
      end
      for (int i = 0; i < 1100; i++) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/soc_system_led_driver.md
SOC_SYSTEM_LED_DRIVER -- requirements
Module: soc_system_led_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 5, giving the number of LED channels.
REQ-002 SHALL have parameter PWM_BITS, default 8, giving the duty and PWM counter width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port led_req, input, NUM_LEDS bits: on/off request from the LED PIO out_port, same clock domain.
REQ-006 SHALL have port address, input, 2 bits: Avalon-MM register address.
REQ-007 SHALL have port chipselect, input, 1 bit: Avalon-MM select.
REQ-008 SHALL have port write_n, input, 1 bit: Avalon-MM write strobe, active-low.
REQ-009 SHALL have port writedata, input, 32 bits: Avalon-MM write data.
REQ-010 SHALL have port readdata, output, 32 bits: Avalon-MM read data, combinational, zero latency.
REQ-011 SHALL have port led_out, output, NUM_LEDS bits: active-high pin drive.

Function
REQ-012 A write SHALL occur when chipselect=1 and write_n=0; register map:
- 0 DUTY[7:0]
- 1 BLINK_EN[NUM_LEDS-1:0]
- 2 PRESCALE[15:0]
- 3 STATUS, read-only; writes ignored.
REQ-013 readdata SHALL return the addressed register zero-extended; STATUS = {blink_phase at bit 8, led_out at bits [NUM_LEDS-1:0]}.
REQ-014 led_req SHALL be registered once (led_req_q) before use.
REQ-015 Prescaler: 16-bit counter; tick=1 for one cycle when counter==PRESCALE, then counter reloads 0; PRESCALE=0 gives tick every cycle.
REQ-016 Any write to PRESCALE SHALL clear the prescaler counter the following cycle; no tick in that cycle.
REQ-017 pwm_cnt (PWM_BITS) SHALL increment on tick and wrap 255->0.
REQ-018 pwm_on SHALL be 1 when pwm_cnt < DUTY, or when DUTY==8'hFF (forced full on); DUTY==0 gives always off.
REQ-019 blink_cnt (8-bit) SHALL increment on each tick where pwm_cnt wraps 255->0; blink_phase = blink_cnt[7].
REQ-020 led_out[i] SHALL be registered: led_req_q[i] & pwm_on & (~BLINK_EN[i] | blink_phase).
REQ-021 Latency: a led_req change SHALL reach led_out exactly 2 clk later, with pwm/blink gating constant.
REQ-022 A DUTY or BLINK_EN write SHALL affect led_out starting 2 cycles after the write cycle; counters are not disturbed.
REQ-023 A PRESCALE write coinciding with a tick: the tick SHALL still take effect; the clear applies next cycle.

Reset
REQ-024 Reset SHALL be asynchronous on reset_n low, with synchronous deassertion handled by the system.
REQ-025 Reset values SHALL be: DUTY=8'hFF, BLINK_EN=0, PRESCALE=0, all counters=0, blink_phase=0, led_req_q=0, led_out=0.
REQ-026 Reset mid-operation SHALL force led_out=0 immediately; output resumes 2 cycles after release.

Structure
REQ-027 Package soc_system_led_pkg SHALL hold register address constants, widths, and reset defaults (DUTY_RST=8'hFF).
REQ-028 The prescaler SHALL be sub-module soc_system_led_tick_gen (clk, reset_n, prescale, clear, tick); everything else is in the top.

Verification
REQ-029 Post-reset, led_req=5'h1F, defaults -> led_out=5'h1F from cycle 2 onward, constantly; STATUS read=0x1F.
REQ-030 DUTY=64, PRESCALE=0, led_req=5'h01 -> led_out[0] high for 64 of every 256 cycles, other bits 0.
REQ-031 DUTY=0 -> led_out=0 regardless of led_req; then DUTY=255 -> led_out=led_req 2 cycles after the write.
REQ-032 BLINK_EN=5'h02, PRESCALE=0, DUTY=255, led_req=5'h03 -> bit0 steady 1; bit1 off 32768 cycles, then on 32768 cycles; STATUS bit8 tracks the phase.
REQ-033 PRESCALE=3 -> tick every 4th cycle; a rewrite of PRESCALE mid-count -> counter restarts at 0, next tick after PRESCALE+1 cycles.
REQ-034 Assert reset_n low mid-blink -> led_out=0 the same cycle; all registers read back reset values.
